// File: rtl/rv32_regfile_pkg.sv
// Shared types, width defaults and packed-slice helper for the barrel register file.
// Latency: none (declarations only); backpressure: not applicable.
package rv32_regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   // Must track XPR_LEN and REG_ADDR_WIDTH in rv32_defines.svh
   localparam int XPR_LEN_DEF  = 32;
   localparam int NUM_REGS_DEF = 32;

   function automatic int slice_lo(input int p, input int w);
      return p * w;
   endfunction

endpackage

// File: rtl/rv32_regfile_bank.sv
// One hart's register array: combinational read ports, single write port, x0 reads as zero.
// Latency: reads are combinational, writes land at the clock edge; no backpressure.
module rv32_regfile_bank
   import rv32_regfile_pkg::*;
#(
   parameter int XPR_LEN        = XPR_LEN_DEF,
   parameter int NUM_REGS       = NUM_REGS_DEF,
   parameter int REG_ADDR_WIDTH = $clog2(NUM_REGS),
   parameter int NUM_RD_PORTS   = 2
) (
   input  logic                                   clk_i,
   input  logic                                   we_i,
   input  logic [REG_ADDR_WIDTH-1:0]              wa_i,
   input  logic [XPR_LEN-1:0]                     wd_i,
   input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] ra_i,
   output logic [NUM_RD_PORTS*XPR_LEN-1:0]        rd_o
);

   logic [XPR_LEN-1:0] mem_q [NUM_REGS];

   always_ff @(posedge clk_i) begin
      if (we_i && (wa_i != '0)) begin
         mem_q[wa_i] <= wd_i;
      end
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      logic [REG_ADDR_WIDTH-1:0] ra_p;
      assign ra_p = ra_i[slice_lo(p, REG_ADDR_WIDTH) +: REG_ADDR_WIDTH];
      assign rd_o[slice_lo(p, XPR_LEN) +: XPR_LEN] = (ra_p == '0) ? '0 : mem_q[ra_p];
   end

endmodule

// File: rtl/rv32_barrel_regfile_mp.sv
// Multi-port per-hart register file with write-first bypass and a hart clear engine.
// Latency: 1 cycle read; no backpressure, clr_req is dropped while clr_busy is high.
module rv32_barrel_regfile_mp
   import rv32_regfile_pkg::*;
#(
   parameter int NUM_HARTS      = 8,
   parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS),
   parameter int XPR_LEN        = XPR_LEN_DEF,
   parameter int NUM_REGS       = NUM_REGS_DEF,
   parameter int REG_ADDR_WIDTH = $clog2(NUM_REGS),
   parameter int NUM_RD_PORTS   = 2
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [HART_CNT_WIDTH-1:0]              rd_hart,
   input  logic [NUM_RD_PORTS-1:0]                ren,
   input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] ra,
   output logic [NUM_RD_PORTS*XPR_LEN-1:0]        rd,
   input  logic                                   wen,
   input  logic [HART_CNT_WIDTH-1:0]              w_hart,
   input  logic [REG_ADDR_WIDTH-1:0]              wa,
   input  logic [XPR_LEN-1:0]                     wd,
   input  logic                                   clr_req,
   input  logic [HART_CNT_WIDTH-1:0]              clr_hart,
   output logic                                   clr_busy
);

   localparam logic [REG_ADDR_WIDTH-1:0] IDX_FIRST = REG_ADDR_WIDTH'(1);
   localparam logic [REG_ADDR_WIDTH-1:0] IDX_LAST  = REG_ADDR_WIDTH'(NUM_REGS - 1);

   clr_state_e                state_q, state_d;
   logic [NUM_HARTS-1:0]      mask_q, mask_d;
   logic [REG_ADDR_WIDTH-1:0] idx_q, idx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         mask_q  <= '1;
         idx_q   <= IDX_FIRST;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d          = CLEAR;
               mask_d           = '0;
               mask_d[clr_hart] = 1'b1;
               idx_d            = IDX_FIRST;
            end
         end
         CLEAR: begin
            // idx holds at the last register rather than wrapping to x0
            if (idx_q == IDX_LAST) state_d = IDLE;
            else                   idx_d   = idx_q + IDX_FIRST;
         end
      endcase
   end

   always_comb begin
      clr_busy = (state_q == CLEAR);
   end

   logic [NUM_HARTS-1:0]              bank_we;
   logic [REG_ADDR_WIDTH-1:0]         bank_wa [NUM_HARTS];
   logic [XPR_LEN-1:0]                bank_wd [NUM_HARTS];
   logic [NUM_RD_PORTS*XPR_LEN-1:0]   bank_rd [NUM_HARTS];

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      logic clr_we;
      assign clr_we = clr_busy && mask_q[h];
      // A hart under clear owns its write port, so user writes to it vanish
      assign bank_we[h] = clr_we || (wen && (w_hart == HART_CNT_WIDTH'(h)));
      assign bank_wa[h] = clr_we ? idx_q : wa;
      assign bank_wd[h] = clr_we ? '0 : wd;

      rv32_regfile_bank #(
         .XPR_LEN        (XPR_LEN),
         .NUM_REGS       (NUM_REGS),
         .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
         .NUM_RD_PORTS   (NUM_RD_PORTS)
      ) u_bank (
         .clk_i (clk),
         .we_i  (bank_we[h]),
         .wa_i  (bank_wa[h]),
         .wd_i  (bank_wd[h]),
         .ra_i  (ra),
         .rd_o  (bank_rd[h])
      );
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      logic [REG_ADDR_WIDTH-1:0] ra_p;
      logic [XPR_LEN-1:0]        rd_d, rd_q;

      assign ra_p = ra[slice_lo(p, REG_ADDR_WIDTH) +: REG_ADDR_WIDTH];

      always_comb begin
         rd_d = bank_rd[rd_hart][slice_lo(p, XPR_LEN) +: XPR_LEN];
         if (bank_we[rd_hart] && (bank_wa[rd_hart] == ra_p)) rd_d = bank_wd[rd_hart];
         if (ra_p == '0) rd_d = '0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)      rd_q <= '0;
         else if (ren[p]) rd_q <= rd_d;
      end

      assign rd[slice_lo(p, XPR_LEN) +: XPR_LEN] = rd_q;
   end

endmodule

// File: tb/tb_rv32_barrel_regfile_mp.sv
// Randomised and directed bench for rv32_barrel_regfile_mp with a queue-based scoreboard.
// Latency: expected read data is due one edge after issue; no backpressure to model.
module tb_rv32_barrel_regfile_mp;

   localparam int NH  = 8;
   localparam int HW  = 3;
   localparam int XL  = 32;
   localparam int NR  = 32;
   localparam int AW  = 5;
   localparam int NP  = 2;
   localparam int RAW = NP * AW;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [HW-1:0]  rd_hart, w_hart, clr_hart;
   logic [NP-1:0]  ren;
   logic [RAW-1:0] ra;
   logic [NP*XL-1:0] rd;
   logic           wen, clr_req, clr_busy;
   logic [AW-1:0]  wa;
   logic [XL-1:0]  wd;

   always #5 clk = ~clk;

   rv32_barrel_regfile_mp dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_hart  (rd_hart),
      .ren      (ren),
      .ra       (ra),
      .rd       (rd),
      .wen      (wen),
      .w_hart   (w_hart),
      .wa       (wa),
      .wd       (wd),
      .clr_req  (clr_req),
      .clr_hart (clr_hart),
      .clr_busy (clr_busy)
   );

   typedef struct {
      int            cyc;
      logic [XL-1:0] r0;
      logic [XL-1:0] r1;
      logic          busy;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Architectural model: plain arrays plus the progress of the current clear
   logic [XL-1:0] mem [NH][NR];
   logic [XL-1:0] m_rd [NP];
   bit            m_busy;
   bit [NH-1:0]   m_mask;
   int            m_next;

   task automatic model_reset();
      for (int p = 0; p < NP; p++) m_rd[p] = '0;
      m_busy = 1'b1;
      m_mask = '1;
      m_next = 1;
   endtask

   task automatic drive_idle();
      ren     = '0;
      wen     = 1'b0;
      clr_req = 1'b0;
   endtask

   task automatic cycle();
      logic [AW-1:0] a;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         model_reset();
      end else begin
         if (m_busy)
            for (int h = 0; h < NH; h++) if (m_mask[h]) mem[h][m_next] = '0;
         if (wen && wa != '0 && !(m_busy && m_mask[w_hart])) mem[w_hart][wa] = wd;
         for (int p = 0; p < NP; p++) begin
            a = ra[p*AW +: AW];
            if (ren[p]) m_rd[p] = (a == '0) ? '0 : mem[rd_hart][a];
         end
         if (m_busy) begin
            m_next++;
            if (m_next == NR) m_busy = 1'b0;
         end else if (clr_req) begin
            m_busy = 1'b1;
            m_mask = '0;
            m_mask[clr_hart] = 1'b1;
            m_next = 1;
         end
      end
      sbq.push_back('{cyc, m_rd[0], m_rd[1], m_busy});
      #1;
      drive_idle();
   endtask

   task automatic rdset(input int h, input int a0, input int a1, input logic [NP-1:0] en);
      rd_hart = HW'(h);
      ra      = {AW'(a1), AW'(a0)};
      ren     = en;
   endtask

   task automatic wrset(input int h, input int a, input logic [XL-1:0] d);
      wen    = 1'b1;
      w_hart = HW'(h);
      wa     = AW'(a);
      wd     = d;
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      sbq.delete();
      model_reset();
      sbq.push_back('{cyc, '0, '0, 1'b1});
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         e = sbq.pop_front();
         checks++;
         if (rd[XL-1:0] !== e.r0) begin
            errors++;
            $display("FAIL rd0 cyc=%0d got=%h exp=%h", e.cyc, rd[XL-1:0], e.r0);
         end
         checks++;
         if (rd[2*XL-1:XL] !== e.r1) begin
            errors++;
            $display("FAIL rd1 cyc=%0d got=%h exp=%h", e.cyc, rd[2*XL-1:XL], e.r1);
         end
         checks++;
         if (clr_busy !== e.busy) begin
            errors++;
            $display("FAIL clr_busy cyc=%0d got=%b exp=%b", e.cyc, clr_busy, e.busy);
         end
      end
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      for (int h = 0; h < NH; h++)
         for (int r = 0; r < NR; r++) mem[h][r] = '0;
      rst_n = 1'b0;
      rd_hart = '0; w_hart = '0; clr_hart = '0; ra = '0; wa = '0; wd = '0;
      drive_idle();
      model_reset();

      // Reset, then the full all-hart clear (busy checked every cycle)
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (33) cycle();

      for (int r = 1; r < NR; r++) begin
         rdset(5, r, NR - r, 2'b11);
         cycle();
      end

      // Basic write then read, other hart unaffected
      wrset(3, 7, 32'hDEADBEEF);
      cycle();
      rdset(3, 7, 0, 2'b11);
      cycle();
      rdset(2, 7, 7, 2'b11);
      cycle();

      // Same-cycle bypass and x0 write discard
      wrset(1, 4, 32'h0000_1234);
      rdset(1, 4, 4, 2'b01);
      cycle();
      wrset(1, 0, 32'hFFFF_FFFF);
      rdset(1, 0, 4, 2'b11);
      cycle();
      rdset(1, 0, 0, 2'b11);
      cycle();

      // Hart 6 clear with concurrent traffic
      for (int n = 1; n < NR; n++) begin
         wrset(6, n, 32'hA5A5_0000 + XL'(n));
         cycle();
      end
      clr_req  = 1'b1;
      clr_hart = 3'd6;
      cycle();
      for (int k = 1; k < 34; k++) begin
         rdset(6, k, k + 1, 2'b11);
         if (k == 1) wrset(6, 3, 32'h55);
         if (k == 2) begin
            wrset(2, 3, 32'h77);
            rdset(2, 3, 3, 2'b10);
         end
         if (k == 3) begin
            clr_req  = 1'b1;
            clr_hart = 3'd2;
         end
         cycle();
      end
      for (int r = 1; r < NR; r++) begin
         rdset(6, r, r, 2'b01);
         cycle();
      end
      rdset(2, 3, 3, 2'b10);
      cycle();

      // Hold: ren low while ra changes
      rdset(6, 5, 0, 2'b11);
      cycle();
      rdset(2, 3, 3, 2'b11);
      cycle();
      for (int k = 0; k < 3; k++) begin
         rdset(1, k + 4, 7 - k, 2'b00);
         cycle();
      end
      rdset(3, 7, 7, 2'b11);
      cycle();
      cycle();

      // Reset in the middle of a hart-4 clear
      wrset(4, 20, 32'h0000_CAFE);
      cycle();
      rdset(4, 20, 20, 2'b11);
      clr_req  = 1'b1;
      clr_hart = 3'd4;
      cycle();
      repeat (9) cycle();
      async_reset();
      repeat (2) cycle();
      rst_n = 1'b1;
      repeat (33) cycle();
      rdset(4, 20, 1, 2'b11);
      cycle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         wen      = 1'($urandom_range(0, 1));
         w_hart   = HW'($urandom);
         wa       = AW'($urandom);
         wd       = $urandom;
         ren      = NP'($urandom);
         ra       = RAW'($urandom);
         rd_hart  = HW'($urandom);
         clr_req  = ($urandom_range(0, 29) == 0);
         clr_hart = HW'($urandom);
         cycle();
      end
      repeat (2) cycle();

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32_barrel_regfile_mp.md
Name: rv32_barrel_regfile_mp

Overview:
- Multi-port, parametrised register file for the barrel-threaded pipeline; one architectural register bank per hart.
- Sits between decode and execute, as the current barrel regfile does. Adds:
  - NUM_RD_PORTS registered read ports with write-first bypass.
  - x0 hardwired to zero.
  - A clear engine that zeroes all harts after reset, or one hart on request (hart restart).

Parameters:
- NUM_HARTS, 8, number of hardware threads (power of two, >=2).
- HART_CNT_WIDTH, $clog2(NUM_HARTS), hart index width.
- XPR_LEN, 32, register data width.
- NUM_REGS, 32, registers per hart (power of two, >=4).
- REG_ADDR_WIDTH, $clog2(NUM_REGS), register address width.
- NUM_RD_PORTS, 2, number of read ports (>=1).

Ports:
- clk  in  1  clock; all state is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_hart  in  HART_CNT_WIDTH  hart selected by all read ports this cycle.
- ren  in  NUM_RD_PORTS  per-port read enable.
- ra  in  NUM_RD_PORTS*REG_ADDR_WIDTH  packed read addresses; port p uses slice p.
- rd  out  NUM_RD_PORTS*XPR_LEN  packed registered read data.
- wen  in  1  write enable.
- w_hart  in  HART_CNT_WIDTH  write hart.
- wa  in  REG_ADDR_WIDTH  write address.
- wd  in  XPR_LEN  write data.
- clr_req  in  1  single-cycle request to zero hart clr_hart.
- clr_hart  in  HART_CNT_WIDTH  hart to clear.
- clr_busy  out  1  clear engine active.

Behaviour:

Reset (rst_n low, asynchronous):
- rd = 0, clr_busy = 1.
- FSM enters CLEAR with mask = all harts, idx = 1.
- Storage array itself is not reset.

Read path:
- Latency 1 cycle. If ren[p] is sampled high at edge N, rd[p] shows the value after edge N.
- ren[p] low: rd[p] holds its previous value.
- ra[p] == 0: rd[p] returns 0 regardless of stored contents.
- Write-first bypass: if a write (user or clear) targets rd_hart/ra[p] in the same cycle, rd[p] returns the written value. This includes a cleared register, which returns 0.

Write path:
- wen with wa == 0 is discarded.
- Otherwise wd is stored in bank[w_hart][wa] at the edge.
- Visible to reads issued in the same cycle via bypass, and to any later read.

Clear FSM, states IDLE and CLEAR:
- IDLE, clr_req high: next state CLEAR, mask = one-hot(clr_hart), idx = 1, clr_busy = 1 from the next cycle.
- CLEAR: each cycle, write 0 to bank[h][idx] for every h in mask; idx increments.
- CLEAR, idx == NUM_REGS-1: after that write, go to IDLE and drop clr_busy.
- A clear lasts exactly NUM_REGS-1 cycles of clr_busy high after the request edge, or after reset deassertion for the reset clear.
- clr_req while clr_busy is high is ignored (not queued).
- User writes to a hart in mask while CLEAR are dropped entirely, even to an already-cleared idx. User writes to other harts proceed normally.
- Reads are allowed during CLEAR and return current contents, subject to the bypass rule.
- rst_n asserted mid-clear restarts a full all-hart clear; the partial per-hart clear is abandoned.

Width rules:
- No arithmetic on data.
- idx is REG_ADDR_WIDTH bits and never wraps: termination is at NUM_REGS-1.

Decomposition:
- Package rv32_regfile_pkg holds:
  - clr_state_e enum (IDLE, CLEAR).
  - Defaults for XPR_LEN and NUM_REGS, kept consistent with XPR_LEN and REG_ADDR_WIDTH in rv32_defines.svh.
  - Packed-slice helper function for port p.
- Sub-module rv32_regfile_bank: one hart's array, NUM_RD_PORTS combinational read ports, one write port, x0 forced to zero.
- The top module instantiates NUM_HARTS banks, the hart read mux, bypass compare, output registers and the clear FSM.

Test Plan:
- Reset release: clr_busy stays high exactly 31 cycles (default parameters), then 0. Afterwards, reading hart 5 regs 1..31 returns 0 on both ports.
- Write hart 3 x7 = 0xDEADBEEF, then next cycle read rd_hart = 3, ra0 = 7, ra1 = 0: one cycle later rd0 = 0xDEADBEEF, rd1 = 0. Hart 2 x7 still reads 0.
- Same cycle: wen to hart 1 x4 = 0x1234 and read hart 1 x4 on port 0: rd0 = 0x1234 next cycle (bypass). A write to x0 = 0xFFFF_FFFF reads back 0.
- Fill hart 6 x1..x31 with 0xA5A5_0000+n, then pulse clr_req with clr_hart = 6. During the clear:
  - Write hart 6 x3 = 0x55: dropped.
  - Write hart 2 x3 = 0x77: lands.
  - Pulse clr_req for hart 2: ignored.
  - Afterwards, hart 6 is all zero and hart 2 x3 = 0x77.
- Hold ren low for 3 cycles while ra changes: rd is unchanged. Raise ren: rd updates one cycle later.
- Assert rst_n low on cycle 10 of a hart-4 clear: rd and clr_busy take reset values immediately. After release, a full all-hart clear runs for 31 cycles.
